// File: rtl/mem_store_buffer.sv
// In-order byte store buffer between the MEM stage and the data-memory write port.
// Drains the oldest entry with a valid/ack handshake and forwards the youngest match to loads.
module mem_store_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     st_valid,
    input  logic [ADDR_W-1:0]        st_addr,
    input  logic [DATA_W-1:0]        st_data,
    output logic                     st_ready,
    output logic                     stall,
    input  logic [ADDR_W-1:0]        ld_addr,
    output logic                     fwd_hit,
    output logic [DATA_W-1:0]        fwd_data,
    output logic                     mem_wr_valid,
    output logic [ADDR_W-1:0]        mem_wr_addr,
    output logic [DATA_W-1:0]        mem_wr_data,
    input  logic                     mem_wr_ack,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DEPTH-1:0]  vld_q, vld_d;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic              push;
    logic              pop;
    logic [PTR_W-1:0]  fwd_idx;

    // Ready looks only at the registered count, keeping ack off the ready path.
    assign st_ready     = count_q < CNT_W'(DEPTH);
    assign empty        = count_q == '0;
    assign mem_wr_valid = ~empty;
    assign stall        = st_valid & ~st_ready;
    assign push         = st_valid & st_ready;
    assign pop          = mem_wr_valid & mem_wr_ack;
    assign mem_wr_addr  = addr_q[rd_ptr_q];
    assign mem_wr_data  = data_q[rd_ptr_q];
    assign count        = count_q;

    // Next-state: popped slot is cleared, pushed slot is written; they never coincide.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        vld_d    = vld_q;
        addr_d   = addr_q;
        data_d   = data_q;
        if (pop) begin
            vld_d[rd_ptr_q]  = 1'b0;
            addr_d[rd_ptr_q] = '0;
            data_d[rd_ptr_q] = '0;
            rd_ptr_d         = rd_ptr_q + PTR_W'(1);
        end
        if (push) begin
            vld_d[wr_ptr_q]  = 1'b1;
            addr_d[wr_ptr_q] = st_addr;
            data_d[wr_ptr_q] = st_data;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Walk oldest to youngest so the last match seen is the youngest.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr_q + PTR_W'(i);
            if (vld_q[fwd_idx] && (addr_q[fwd_idx] == ld_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[fwd_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            vld_q    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            vld_q    <= vld_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

endmodule

// File: tb/tb_mem_store_buffer.sv
// Scoreboard bench for mem_store_buffer: queue-based reference model, directed
// scenarios followed by randomized push/ack/load traffic.
module tb_mem_store_buffer;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 8;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } ent_t;

    logic              clk;
    logic              reset;
    logic              st_valid;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic              st_ready;
    logic              stall;
    logic [ADDR_W-1:0] ld_addr;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic              mem_wr_valid;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic              mem_wr_ack;
    logic              empty;
    logic [2:0]        count;

    int n_tests = 0;
    int n_fail  = 0;

    ent_t mdl[$];    // current buffer contents, oldest first
    ent_t exp_q[$];  // expected drain order for the monitor

    mem_store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
        .st_ready(st_ready), .stall(stall),
        .ld_addr(ld_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .mem_wr_valid(mem_wr_valid), .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data), .mem_wr_ack(mem_wr_ack),
        .empty(empty), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [ADDR_W-1:0] act, input logic [ADDR_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, then advance the model.
    task automatic cycle(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                         input logic ack, input logic [ADDR_W-1:0] ld);
        int   cnt;
        logic hit;
        logic [DATA_W-1:0] fd;
        ent_t e;
        @(posedge clk);
        #1;
        st_valid   = v;
        st_addr    = a;
        st_data    = d;
        mem_wr_ack = ack;
        ld_addr    = ld;
        #3;
        cnt = mdl.size();
        hit = 1'b0;
        fd  = '0;
        for (int i = cnt - 1; i >= 0; i--) begin
            if (mdl[i].a == ld) begin
                hit = 1'b1;
                fd  = mdl[i].d;
                break;
            end
        end
        chk("count", ADDR_W'(count), ADDR_W'(cnt));
        chk("empty", ADDR_W'(empty), ADDR_W'(cnt == 0));
        chk("st_ready", ADDR_W'(st_ready), ADDR_W'(cnt < DEPTH));
        chk("stall", ADDR_W'(stall), ADDR_W'(v && cnt >= DEPTH));
        chk("mem_wr_valid", ADDR_W'(mem_wr_valid), ADDR_W'(cnt != 0));
        chk("fwd_hit", ADDR_W'(fwd_hit), ADDR_W'(hit));
        chk("fwd_data", ADDR_W'(fwd_data), ADDR_W'(fd));
        if (cnt != 0) begin
            chk("head_addr", mem_wr_addr, mdl[0].a);
            chk("head_data", ADDR_W'(mem_wr_data), ADDR_W'(mdl[0].d));
        end
        if (ack && cnt > 0) void'(mdl.pop_front());
        if (v && cnt < DEPTH) begin
            e.a = a;
            e.d = d;
            mdl.push_back(e);
            exp_q.push_back(e);
        end
    endtask

    task automatic drain();
        repeat (DEPTH + 1) cycle(1'b0, '0, '0, 1'b1, '0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_empty"}, ADDR_W'(empty), 1);
        chk({tag, "_st_ready"}, ADDR_W'(st_ready), 1);
        chk({tag, "_valid"}, ADDR_W'(mem_wr_valid), 0);
        chk({tag, "_count"}, ADDR_W'(count), 0);
        chk({tag, "_stall"}, ADDR_W'(stall), 0);
        chk({tag, "_fwd_hit"}, ADDR_W'(fwd_hit), 0);
        chk({tag, "_fwd_data"}, ADDR_W'(fwd_data), 0);
        chk({tag, "_wr_addr"}, mem_wr_addr, 0);
        chk({tag, "_wr_data"}, ADDR_W'(mem_wr_data), 0);
    endtask

    // Drain-side scoreboard: every accepted write must match the oldest expected store.
    always @(negedge clk) begin
        if (reset && mem_wr_valid && mem_wr_ack) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL drain_unexpected: got addr 0x%0h with nothing expected", mem_wr_addr);
            end else begin
                ent_t e;
                e = exp_q.pop_front();
                chk("drain_addr", mem_wr_addr, e.a);
                chk("drain_data", ADDR_W'(mem_wr_data), ADDR_W'(e.d));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ADDR_W-1:0] pool [5];
        pool[0] = 32'h40; pool[1] = 32'h41; pool[2] = 32'h42;
        pool[3] = 32'h43; pool[4] = 32'h8000_0040;

        reset = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0;
        mem_wr_ack = 1'b0; ld_addr = '0;

        // Reset held for three cycles, then released
        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("rst");
        reset = 1'b1;
        cycle(1'b0, '0, '0, 1'b0, '0);

        // Fill to full, then a rejected fifth store
        for (int i = 0; i < 4; i++)
            cycle(1'b1, ADDR_W'(32'h10 + i), DATA_W'(8'hA0 + i), 1'b0, '0);
        cycle(1'b1, 32'h14, 8'hA4, 1'b0, 32'h14);
        cycle(1'b0, '0, '0, 1'b0, 32'h14);

        // In-order drain
        drain();

        // Forwarding: youngest of two matches wins; same-cycle push does not forward
        cycle(1'b1, 32'h40, 8'h11, 1'b0, '0);
        cycle(1'b1, 32'h40, 8'h22, 1'b0, '0);
        cycle(1'b0, '0, '0, 1'b0, 32'h40);
        cycle(1'b0, '0, '0, 1'b0, 32'h44);
        cycle(1'b1, 32'h44, 8'h33, 1'b0, 32'h44);
        cycle(1'b0, '0, '0, 1'b0, 32'h44);

        // Push+pop at count=2, then full with ack rejects the push
        cycle(1'b0, '0, '0, 1'b1, 32'h40);
        cycle(1'b1, 32'h50, 8'h55, 1'b1, 32'h40);
        cycle(1'b1, 32'h51, 8'h56, 1'b0, '0);
        cycle(1'b1, 32'h52, 8'h57, 1'b0, '0);
        cycle(1'b1, 32'h60, 8'h66, 1'b1, 32'h60);
        cycle(1'b0, '0, '0, 1'b0, 32'h60);
        drain();

        // Ten stores streamed through, wrapping both pointers
        for (int i = 0; i < 10; i++)
            cycle(1'b1, ADDR_W'(32'h100 + i), DATA_W'(i), 1'(i % 3 != 0), '0);
        drain();

        // Randomized traffic
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 1)), pool[$urandom_range(0, 4)], DATA_W'($urandom),
                  1'($urandom_range(0, 2) != 0), pool[$urandom_range(0, 4)]);
        drain();

        // Reset during an outstanding write
        cycle(1'b1, 32'h200, 8'h77, 1'b0, '0);
        cycle(1'b1, 32'h201, 8'h78, 1'b0, 32'h200);
        @(posedge clk);
        #2;
        chk("pre_rst_valid", ADDR_W'(mem_wr_valid), 1);
        reset = 1'b0;
        #1;
        chk("async_rst_valid", ADDR_W'(mem_wr_valid), 0);
        chk("async_rst_count", ADDR_W'(count), 0);
        chk("async_rst_fwd", ADDR_W'(fwd_hit), 0);
        mdl.delete();
        exp_q.delete();
        st_valid = 1'b0;
        mem_wr_ack = 1'b0;
        ld_addr = '0;
        repeat (2) @(posedge clk);
        #2;
        check_reset_outputs("rst2");
        reset = 1'b1;

        // Buffer still works after the abandoned write
        cycle(1'b1, 32'h300, 8'h99, 1'b0, '0);
        cycle(1'b0, '0, '0, 1'b0, 32'h300);
        drain();
        chk("scoreboard_empty", ADDR_W'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
